// File: rtl/adaptive_filter_out_buf_pkg.sv
// Shared types for the adaptive filter output buffer: Q8.6 sample type,
// FIFO entry layout and output FSM state encoding.
package adaptive_filter_pkg;

    localparam int DATA_WIDTH        = 14;
    localparam int FRACTIONAL_LENGTH = 6;

    typedef logic signed [DATA_WIDTH-FRACTIONAL_LENGTH-1:-FRACTIONAL_LENGTH] sample_t;

    typedef struct packed {
        sample_t data;
        logic    mode;
        logic    last;
    } fifo_entry_t;

    localparam int ENTRY_W = $bits(fifo_entry_t);

    typedef enum logic {
        ST_EMPTY,
        ST_HOLD
    } out_state_e;

endpackage

// File: rtl/adaptive_filter_out_buf_if.sv
// Stream bundle between adaptive_filter, the output buffer and its consumer.
// slave: the buffer's view; master: the environment driving/consuming it.
interface adaptive_filter_out_buf_if;
    import adaptive_filter_pkg::*;

    sample_t s_tdata;
    logic    s_tvalid;
    logic    ctrl;
    sample_t m_tdata;
    logic    m_tvalid;
    logic    m_tready;
    logic    m_tlast;
    logic    m_tuser;

    modport slave (
        input  s_tdata, s_tvalid, ctrl, m_tready,
        output m_tdata, m_tvalid, m_tlast, m_tuser
    );

    modport master (
        output s_tdata, s_tvalid, ctrl, m_tready,
        input  m_tdata, m_tvalid, m_tlast, m_tuser
    );
endinterface

// File: rtl/adaptive_filter_out_buf_sync_fifo.sv
// Single-clock FIFO storage; pointers carry one extra wrap bit so full and
// empty are distinguished by the MSB. Push while full is honoured only when
// a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Pointer update and status flags
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
        rdata    = mem[rd_ptr_q[AW-1:0]];
    end

    // Pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array, no reset needed: contents are only visible via rd_ptr
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end
endmodule

// File: rtl/adaptive_filter_out_buf.sv
// Output buffer for adaptive_filter: framing (tlast), mode tagging (tuser),
// sticky overflow detection and an AXI-Stream output stage with a
// registered head entry in front of sync_fifo.
// Optional: ADAPTIVE_FILTER_OUT_BUF_OVF_CNT_EN adds the 8-bit ovf_cnt output.
module adaptive_filter_out_buf
    import adaptive_filter_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int FRAME_LEN  = 16
) (
    input  logic                       clk,
    input  logic                       arst_n,
    adaptive_filter_out_buf_if.slave   bus,
    output logic                       ovf,
    input  logic                       ovf_clr
`ifdef ADAPTIVE_FILTER_OUT_BUF_OVF_CNT_EN
    ,
    output logic [7:0]                 ovf_cnt
`endif
);
    localparam int CNT_W = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;

    logic        rst_meta_q, rst_meta_d, rst_sync_q, rst_sync_d;
    out_state_e  state_q, state_d;
    fifo_entry_t head_q, head_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cur_cnt;
    logic        mode_q, mode_d;
    logic        ovf_q, ovf_d;
    logic        pop_out, fifo_pop, fifo_full, fifo_empty, accept, drop;
    fifo_entry_t wr_entry;
    logic [ENTRY_W-1:0] fifo_rdata;

    // Reset synchroniser: assert immediately, release two edges later
    always_comb begin
        rst_meta_d = 1'b1;
        rst_sync_d = rst_meta_q;
    end

    // Reset synchroniser flops
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= rst_meta_d;
            rst_sync_q <= rst_sync_d;
        end
    end

    // Write side: framing, acceptance and overflow tracking
    always_comb begin
        pop_out       = (state_q == ST_HOLD) && bus.m_tready;
        fifo_pop      = !fifo_empty && ((state_q == ST_EMPTY) || pop_out);
        accept        = bus.s_tvalid && (!fifo_full || pop_out);
        drop          = bus.s_tvalid && !accept;
        cur_cnt       = (bus.ctrl != mode_q) ? '0 : cnt_q;
        wr_entry.data = bus.s_tdata;
        wr_entry.mode = bus.ctrl;
        wr_entry.last = (cur_cnt == CNT_W'(FRAME_LEN - 1));
        cnt_d         = cnt_q;
        mode_d        = mode_q;
        if (bus.s_tvalid) begin
            cnt_d  = wr_entry.last ? '0 : cur_cnt + CNT_W'(1);
            mode_d = bus.ctrl;
        end
        ovf_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
        head_d = fifo_pop ? fifo_entry_t'(fifo_rdata) : head_q;
    end

    // Output FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (!fifo_empty) state_d = ST_HOLD;
            ST_HOLD:  if (pop_out && fifo_empty) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Output FSM outputs
    always_comb begin
        bus.m_tvalid = (state_q == ST_HOLD);
        bus.m_tdata  = head_q.data;
        bus.m_tlast  = head_q.last;
        bus.m_tuser  = head_q.mode;
        ovf          = ovf_q;
    end

    // State, head entry, frame counter and overflow registers
    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef ADAPTIVE_FILTER_OUT_BUF_OVF_CNT_EN
    logic [7:0] ovf_cnt_q, ovf_cnt_d;

    // Saturating dropped-sample counter; a drop in the clearing cycle counts
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (ovf_clr) begin
            ovf_cnt_d = drop ? 8'd1 : '0;
        end else if (drop && (ovf_cnt_q != '1)) begin
            ovf_cnt_d = ovf_cnt_q + 8'd1;
        end
        ovf_cnt = ovf_cnt_q;
    end

    // Dropped-sample counter register
    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end
`endif

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_sync_q),
        .push  (accept),
        .pop   (fifo_pop),
        .wdata (wr_entry),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
endmodule

// File: tb/tb_adaptive_filter_out_buf.sv
// Self-checking bench for adaptive_filter_out_buf: directed scenarios plus
// randomized traffic, compared each cycle against a queue-based model.
module tb_adaptive_filter_out_buf;
    localparam int DEPTH = 8;
    localparam int FL    = 16;

    logic clk;
    logic arst_n;
    logic ovf;
    logic ovf_clr;
`ifdef ADAPTIVE_FILTER_OUT_BUF_OVF_CNT_EN
    logic [7:0] ovf_cnt;
`endif

    adaptive_filter_out_buf_if bus ();

    adaptive_filter_out_buf #(
        .FIFO_DEPTH (DEPTH),
        .FRAME_LEN  (FL)
    ) dut (
        .clk     (clk),
        .arst_n  (arst_n),
        .bus     (bus.slave),
        .ovf     (ovf),
        .ovf_clr (ovf_clr)
`ifdef ADAPTIVE_FILTER_OUT_BUF_OVF_CNT_EN
        ,
        .ovf_cnt (ovf_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: every stored sample in order as {data[13:0], mode, last};
    // m_hv says whether the output register currently presents m_q[0].
    logic [15:0] m_q [$];
    bit          m_hv;
    int          m_cnt;
    bit          m_mode;
    bit          m_ovf;
    int          m_ocnt;

    int hs_idx;
    int last_idx [$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_hv   = 1'b0;
        m_cnt  = 0;
        m_mode = 1'b0;
        m_ovf  = 1'b0;
        m_ocnt = 0;
    endtask

    // One clock: check outputs at negedge, drive inputs, advance the model.
    task automatic step(input bit v, input logic [13:0] d, input bit c, input bit rdy, input bit clr);
        int  fc;
        bit  pop, acc, lst;
        @(negedge clk);
        chk("m_tvalid", {31'b0, bus.m_tvalid}, {31'b0, m_hv});
        if (m_hv) begin
            chk("m_tdata", {18'b0, bus.m_tdata}, {18'b0, m_q[0][15:2]});
            chk("m_tuser", {31'b0, bus.m_tuser}, {31'b0, m_q[0][1]});
            chk("m_tlast", {31'b0, bus.m_tlast}, {31'b0, m_q[0][0]});
            if (rdy) begin
                if (m_q[0][0]) last_idx.push_back(hs_idx);
                hs_idx++;
            end
        end
        chk("ovf", {31'b0, ovf}, {31'b0, m_ovf});
`ifdef ADAPTIVE_FILTER_OUT_BUF_OVF_CNT_EN
        chk("ovf_cnt", {24'b0, ovf_cnt}, m_ocnt);
`endif
        bus.s_tvalid = v;
        bus.s_tdata  = d;
        bus.ctrl     = c;
        bus.m_tready = rdy;
        ovf_clr      = clr;

        fc  = m_q.size() - (m_hv ? 1 : 0);
        pop = m_hv && rdy;
        acc = v && ((fc < DEPTH) || pop);
        lst = 1'b0;
        if (v) begin
            if (c != m_mode) m_cnt = 0;
            lst    = (m_cnt == FL - 1);
            m_cnt  = lst ? 0 : m_cnt + 1;
            m_mode = c;
        end
        m_hv = (m_hv && !pop) || (fc > 0);
        if (pop) void'(m_q.pop_front());
        if (acc) m_q.push_back({d, c, lst});
        if (v && !acc) begin
            m_ovf = 1'b1;
        end else if (clr) begin
            m_ovf = 1'b0;
        end
        if (clr) begin
            m_ocnt = (v && !acc) ? 1 : 0;
        end else if (v && !acc && m_ocnt < 255) begin
            m_ocnt++;
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 14'd0, m_mode, rdy, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.s_tvalid = 1'b0;
        ovf_clr      = 1'b0;
        arst_n       = 1'b0;
        #1;
        chk("rst_tvalid", {31'b0, bus.m_tvalid}, 32'd0);
        chk("rst_tdata", {18'b0, bus.m_tdata}, 32'd0);
        chk("rst_tlast", {31'b0, bus.m_tlast}, 32'd0);
        chk("rst_tuser", {31'b0, bus.m_tuser}, 32'd0);
        chk("rst_ovf", {31'b0, ovf}, 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        idle(3, 1'b0);
    endtask

    initial begin
        bit c;
        arst_n       = 1'b0;
        bus.s_tvalid = 1'b0;
        bus.s_tdata  = '0;
        bus.ctrl     = 1'b0;
        bus.m_tready = 1'b0;
        ovf_clr      = 1'b0;
        model_reset();
        hs_idx = 0;

        do_reset();

        // Single 1.0 sample, consumer ready
        step(1'b1, 14'h0040, 1'b1, 1'b1, 1'b0);
        idle(4, 1'b1);

        // Overflow: 10 samples into a stalled consumer, then drain
        for (int i = 0; i < 10; i++) step(1'b1, 14'(100 + i), 1'b1, 1'b0, 1'b0);
        idle(1, 1'b0);
        chk("ovf_set", {31'b0, ovf}, 32'd1);
        idle(12, 1'b1);
        step(1'b0, 14'd0, 1'b1, 1'b1, 1'b1);
        idle(2, 1'b1);

        // Reset with 5 samples buffered
        for (int i = 0; i < 5; i++) step(1'b1, 14'(200 + i), 1'b0, 1'b0, 1'b0);
        do_reset();
        idle(3, 1'b1);

        // 32 continuous samples, one frame boundary every 16
        hs_idx = 0;
        last_idx.delete();
        for (int i = 0; i < 32; i++) step(1'b1, 14'(i), 1'b0, 1'b1, 1'b0);
        idle(4, 1'b1);
        chk("last_count", last_idx.size(), 32'd2);
        if (last_idx.size() == 2) begin
            chk("last_pos0", last_idx[0], 32'd15);
            chk("last_pos1", last_idx[1], 32'd31);
        end

        // Mode toggle after sample 5 restarts the frame at sample 6
        hs_idx = 0;
        last_idx.delete();
        for (int i = 0; i < 26; i++) step(1'b1, 14'(300 + i), (i >= 6), 1'b1, 1'b0);
        idle(4, 1'b1);
        chk("toggle_last_count", last_idx.size(), 32'd1);
        if (last_idx.size() == 1) chk("toggle_last_pos", last_idx[0], 32'd21);

        // Full buffer with simultaneous push and pop
        for (int i = 0; i < 9; i++) step(1'b1, 14'(400 + i), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 14'(500 + i), 1'b1, 1'b1, 1'b0);
        idle(1, 1'b1);
        chk("full_pushpop_ovf", {31'b0, ovf}, 32'd0);
        idle(14, 1'b1);

        // Randomized traffic
        c = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(9) == 0) c = ~c;
            step(($urandom_range(9) < 7), 14'($urandom), c,
                 ($urandom_range(1) == 1), ($urandom_range(19) == 0));
        end
        idle(20, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
